// File: rtl/log2_arbiter.sv
// Two-requester front end sharing one log2 approximator; one result slot with
// round-robin arbitration, per-requester accept counters and a sticky zero-operand flag.

// Leading-one log2: integer part is the leading-one position minus 12, fraction is the
// bits below the leading one (linear interpolation). Integer part wraps for x < 2^-8.
module log2_approx (
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);
  logic [3:0] lead;

  always_comb begin
    lead = '0;
    for (int i = 0; i < 16; i++) begin
      if (x_i[i]) lead = 4'(i);
    end
  end

  assign y_o = {lead - 4'd12, 12'({x_i, 12'b0} >> lead)};
endmodule

module log2_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in0_valid,
  input  logic [15:0] in0_data,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [15:0] in1_data,
  output logic        in1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_id,
  output logic        out_zero,
  output logic        zero_err,
  output logic [7:0]  cnt0,
  output logic [7:0]  cnt1
);
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_id_q, out_id_d;
  logic        out_zero_q, out_zero_d;
  logic        zero_err_q, zero_err_d;
  logic [7:0]  cnt0_q, cnt0_d;
  logic [7:0]  cnt1_q, cnt1_d;
  logic        ptr_q, ptr_d;

  logic        slot_free;
  logic        gnt0, gnt1, accept;
  logic [15:0] sel_data;
  logic [15:0] log2_res;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && slot_free) begin
      if (in0_valid && (!in1_valid || !ptr_q)) gnt0 = 1'b1;
      else if (in1_valid)                      gnt1 = 1'b1;
    end
  end

  assign accept    = gnt0 || gnt1;
  assign sel_data  = gnt1 ? in1_data : in0_data;
  assign in0_ready = gnt0;
  assign in1_ready = gnt1;

  log2_approx u_log2 (
    .x_i (sel_data),
    .y_o (log2_res)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_zero_d  = out_zero_q;
    zero_err_d  = zero_err_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_id_d    = gnt1;
      ptr_d       = gnt0;  // point at the requester that lost this round
      if (sel_data == 16'h0000) begin
        out_data_d = 16'h0000;
        out_zero_d = 1'b1;
        zero_err_d = 1'b1;
      end else begin
        out_data_d = log2_res;
        out_zero_d = 1'b0;
      end
      if (gnt0 && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
      if (gnt1 && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_id_q    <= 1'b0;
      out_zero_q  <= 1'b0;
      zero_err_q  <= 1'b0;
      cnt0_q      <= 8'h00;
      cnt1_q      <= 8'h00;
      ptr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_zero_q  <= out_zero_d;
      zero_err_q  <= zero_err_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_zero  = out_zero_q;
  assign zero_err  = zero_err_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
endmodule

// File: tb/tb_log2_arbiter.sv
// Randomized + directed bench for log2_arbiter: reference model predicts grants and
// results, a scoreboard queue carries expected results to an independent monitor.
module tb_log2_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in1_valid, in0_ready, in1_ready;
  logic [15:0] in0_data, in1_data;
  logic        out_valid, out_ready, out_id, out_zero, zero_err;
  logic [15:0] out_data;
  logic [7:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  log2_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_zero  (out_zero),
    .zero_err  (zero_err),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        id;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  logic m_full = 1'b0, m_ptr = 1'b0, m_zerr = 1'b0;
  logic m_acc0 = 1'b0, m_acc1 = 1'b0;
  int   m_cnt0 = 0, m_cnt1 = 0;
  logic m_free, m_g0, m_g1;
  logic [15:0] m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // log2(x) with x in Q4.12: floor(log2) from the leading power of two, plus the
  // linear fraction (x - 2^p) / 2^p, both scaled by 4096; wraps modulo 2^16.
  function automatic logic [15:0] ref_log2(input logic [15:0] x);
    int xi, p, frac;
    xi = int'(x);
    if (xi == 0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 16; i++) if (xi >= (1 << i)) p = i;
    frac = ((xi - (1 << p)) * 4096) / (1 << p);
    return 16'((p - 12) * 4096 + frac);
  endfunction

  always @(negedge clk) begin
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    check("cnt0", {24'b0, cnt0}, 32'(m_cnt0));
    check("cnt1", {24'b0, cnt1}, 32'(m_cnt1));
    check("zero_err", {31'b0, zero_err}, {31'b0, m_zerr});
    m_free = !m_full || out_ready;
    m_g0   = 1'b0;
    m_g1   = 1'b0;
    if (!rst && m_free) begin
      if (in0_valid && in1_valid) begin
        m_g0 = !m_ptr;
        m_g1 = m_ptr;
      end else begin
        m_g0 = in0_valid;
        m_g1 = in1_valid;
      end
    end
    check("in0_ready", {31'b0, in0_ready}, {31'b0, m_g0});
    check("in1_ready", {31'b0, in1_ready}, {31'b0, m_g1});
    m_acc0 = m_g0;
    m_acc1 = m_g1;
    if (rst) begin
      m_full = 1'b0; m_ptr = 1'b0; m_zerr = 1'b0;
      m_cnt0 = 0;    m_cnt1 = 0;
      sb.delete();
    end else if (m_g0 || m_g1) begin
      m_sel = m_g1 ? in1_data : in0_data;
      sb.push_back('{data: ref_log2(m_sel), id: m_g1, zero: (m_sel == 16'h0000)});
      m_full = 1'b1;
      m_ptr  = m_g0;
      if (m_sel == 16'h0000) m_zerr = 1'b1;
      if (m_g0 && m_cnt0 < 255) m_cnt0++;
      if (m_g1 && m_cnt1 < 255) m_cnt1++;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  end

  // Monitor: compares the held result every cycle it is presented, pops on take.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got data %0h id %0b, expected no result at %0t",
                 out_data, out_id, $time);
      end else begin
        check("out_data", {16'b0, out_data}, {16'b0, sb[0].data});
        check("out_id", {31'b0, out_id}, {31'b0, sb[0].id});
        check("out_zero", {31'b0, out_zero}, {31'b0, sb[0].zero});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic cyc(input logic v0, input logic [15:0] d0, input logic v1,
                     input logic [15:0] d1, input logic rdy, input logic r);
    @(negedge clk);
    in0_valid = v0;
    in0_data  = d0;
    in1_valid = v1;
    in1_data  = d1;
    out_ready = rdy;
    rst       = r;
  endtask

  function automatic logic [15:0] rand_data();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'(1 << $urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_cleared(input string tag);
    #3;
    check({tag, "_out_data"}, {16'b0, out_data}, 32'h0);
    check({tag, "_out_id"}, {31'b0, out_id}, 32'h0);
    check({tag, "_out_zero"}, {31'b0, out_zero}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; out_ready = 1'b0;

    cyc(1, 16'h1234, 1, 16'h4321, 1, 1);  // readies must stay low under reset
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0);
    check_cleared("reset");

    // Single request: log2(1.0) = 0
    cyc(1, 16'h1000, 0, 16'h0000, 1, 0);
    repeat (2) cyc(0, 16'h0000, 0, 16'h0000, 1, 0);

    // Contention from reset: id0, id1 alternating, no bubbles
    cyc(0, 16'h0000, 0, 16'h0000, 1, 1);
    repeat (10) cyc(1, 16'h2000, 1, 16'h8000, 1, 0);
    repeat (2) cyc(0, 16'h0000, 0, 16'h0000, 1, 0);

    // Backpressure, then drain and refill in the same cycle
    repeat (5) cyc(1, 16'h0800, 1, 16'h4000, 0, 0);
    repeat (3) cyc(1, 16'h0800, 1, 16'h4000, 1, 0);
    repeat (2) cyc(0, 16'h0000, 0, 16'h0000, 1, 0);

    // Zero operand, sticky flag through later results
    cyc(0, 16'h0000, 1, 16'h0000, 1, 0);
    repeat (4) cyc(0, 16'h0000, 1, 16'h3000, 1, 0);
    repeat (2) cyc(0, 16'h0000, 0, 16'h0000, 0, 0);

    // Saturation of cnt0
    repeat (300) cyc(1, 16'h1234, 0, 16'h0000, 1, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0);

    // Reset while a result is held
    cyc(1, 16'h5000, 0, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 16'h0000, 0, 0);
    check_cleared("midreset");
    repeat (2) cyc(1, 16'h0400, 1, 16'h0C00, 1, 0);  // pointer back at 0: id0 first
    cyc(0, 16'h0000, 0, 16'h0000, 1, 0);

    // Random traffic; offered operands held until the model sees them accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!(in0_valid && !m_acc0)) begin
        in0_valid = ($urandom_range(0, 2) != 0);
        in0_data  = rand_data();
      end
      if (!(in1_valid && !m_acc1)) begin
        in1_valid = ($urandom_range(0, 2) != 0);
        in1_data  = rand_data();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
    end

    repeat (4) cyc(0, 16'h0000, 0, 16'h0000, 1, 0);
    #3;
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
